// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 program RAM, IR, A/B registers, ALU and OUT
// register around a single prioritised 8-bit W bus driven by the sequencer's control word.
module sap1_datapath (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [11:0] cntrl_bus,
    output logic [3:0]  opcode,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [7:0]  prog_data,
    output logic [7:0]  out_reg,
    output logic [7:0]  w_bus,
    output logic [7:0]  acc,
    output logic [3:0]  pc,
    output logic        bus_err
);

    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
    assign {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n} = cntrl_bus;

    logic [3:0] pc_reg;
    logic [3:0] mar_reg;
    logic [7:0] ir_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] outp_reg;
    logic       bus_err_reg;
    logic [7:0] ram [16];

    logic [7:0] alu_res;
    logic [7:0] bus_val;
    logic [4:0] drv_en;
    logic [7:0] drv_val [5];
    logic       contention;

    assign alu_res = su ? (a_reg - b_reg) : (a_reg + b_reg);

    // Index 4 is the highest-priority driver; the loop lets higher indices win.
    assign drv_en     = {ep, ~ce_n, ~ei_n, ea, eu};
    assign drv_val[4] = {4'h0, pc_reg};
    assign drv_val[3] = ram[mar_reg];
    assign drv_val[2] = {4'h0, ir_reg[3:0]};
    assign drv_val[1] = a_reg;
    assign drv_val[0] = alu_res;

    always_comb begin
        bus_val = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (drv_en[i]) begin
                bus_val = drv_val[i];
            end
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign contention = |(drv_en & (drv_en - 5'd1));

    // Program RAM has no reset so a program loaded under CLR survives it.
    always_ff @(posedge CLK) begin
        if (prog_we) begin
            ram[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pc_reg      <= 4'h0;
            mar_reg     <= 4'h0;
            ir_reg      <= 8'h00;
            a_reg       <= 8'h00;
            b_reg       <= 8'h00;
            outp_reg    <= 8'h00;
            bus_err_reg <= 1'b0;
        end else begin
            if (cp) begin
                pc_reg <= pc_reg + 4'h1;
            end
            if (!lm_n) begin
                mar_reg <= bus_val[3:0];
            end
            if (!li_n) begin
                ir_reg <= bus_val;
            end
            if (!la_n) begin
                a_reg <= bus_val;
            end
            if (!lb_n) begin
                b_reg <= bus_val;
            end
            if (!lo_n) begin
                outp_reg <= bus_val;
            end
            if (contention) begin
                bus_err_reg <= 1'b1;
            end
        end
    end

    assign opcode  = ir_reg[7:4];
    assign out_reg = outp_reg;
    assign w_bus   = bus_val;
    assign acc     = a_reg;
    assign pc      = pc_reg;
    assign bus_err = bus_err_reg;

endmodule
